// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains the byte FIFO read port and decodes
// length-prefixed frames into a 2-deep valid/ready payload stream.
module fifo_frame_reader #(
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   read_clk,
    input  logic                   read_rst,
    input  logic                   fifo_empty,
    input  logic [7:0]             fifo_rd_data,
    output logic                   fifo_rd_en,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   in_frame,
    output logic [FRAME_CNT_W-1:0] frame_count
);
    typedef enum logic {
        ST_LEN,
        ST_PAYLOAD
    } rx_state_e;

    rx_state_e              state_q, state_d;
    logic [8:0]             rem_q, rem_d;
    logic                   inflight_q;
    logic [1:0]             occ_q, occ_d;
    logic [1:0][7:0]        data_q, data_d;
    logic [1:0]             last_q, last_d;
    logic                   in_frame_q, in_frame_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

    logic       pop;
    logic       push;
    logic       len_dec;
    logic       rd_en;
    logic       wr_hi;
    logic [2:0] fill;

    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign len_dec   = inflight_q && (state_q == ST_LEN);
    assign push      = inflight_q && (state_q == ST_PAYLOAD);

    // Entries committed or already on their way, net of this cycle's pop.
    assign fill  = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign rd_en = !read_rst && !fifo_empty && (fill < 3'd2);

    // The incoming byte lands in slot 1 only if one entry survives the pop.
    assign wr_hi = ((occ_q - 2'(pop)) == 2'd1);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        occ_d      = occ_q;
        data_d     = data_q;
        last_d     = last_q;
        in_frame_d = in_frame_q;
        fcnt_d     = fcnt_q;

        if (pop) begin
            data_d[0] = data_q[1];
            last_d[0] = last_q[1];
            if (last_q[0]) begin
                fcnt_d     = fcnt_q + FRAME_CNT_W'(1);
                in_frame_d = 1'b0;
            end
        end

        if (len_dec) begin
            rem_d      = {(fifo_rd_data == 8'd0), fifo_rd_data};
            state_d    = ST_PAYLOAD;
            in_frame_d = 1'b1;
        end

        if (push) begin
            data_d[wr_hi] = fifo_rd_data;
            last_d[wr_hi] = (rem_q == 9'd1);
            rem_d         = rem_q - 9'd1;
            if (rem_q == 9'd1) begin
                state_d = ST_LEN;
            end
        end

        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            state_q    <= ST_LEN;
            rem_q      <= 9'd0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            data_q     <= '0;
            last_q     <= 2'b00;
            in_frame_q <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            inflight_q <= rd_en;
            occ_q      <= occ_d;
            data_q     <= data_d;
            last_q     <= last_d;
            in_frame_q <= in_frame_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign fifo_rd_en  = rd_en;
    assign out_data    = data_q[0];
    assign out_last    = last_q[0] && out_valid;
    assign in_frame    = in_frame_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader: a byte-FIFO model feeds
// directed frames; a negedge monitor checks payload and probes.
module tb_fifo_frame_reader;
    localparam int CW = 16;

    localparam int P_VALID   = 0;
    localparam int P_DATA    = 1;
    localparam int P_LAST    = 2;
    localparam int P_INFRAME = 3;
    localparam int P_FCNT    = 4;
    localparam int P_RDEN    = 5;
    localparam int P_RDPTR   = 6;
    localparam int P_SBEMPTY = 7;
    localparam int P_TIMEOUT = 8;

    typedef struct {
        int    kind;
        int    exp;
        string name;
    } probe_t;

    logic          clk = 1'b0;
    logic          read_rst = 1'b1;
    logic          fifo_empty;
    logic [7:0]    fifo_rd_data = 8'd0;
    logic          fifo_rd_en;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          in_frame;
    logic [CW-1:0] frame_count;

    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    logic [8:0] exp_q [$];
    probe_t     probe_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    fifo_frame_reader #(.FRAME_CNT_W(CW)) dut (
        .read_clk     (clk),
        .read_rst     (read_rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .in_frame     (in_frame),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    // Byte FIFO with one-cycle registered read latency.
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        probe_t     p;
        int         act;
        if (fifo_empty) begin
            n_checks++;
            if (fifo_rd_en) begin
                n_fail++;
                $display("FAIL rd_while_empty: rd_en=%0b want 0",
                         fifo_rd_en);
            end
        end
        if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_byte: got %02h/%0b want none",
                         out_data, out_last);
            end else begin
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL payload: got %02h/%0b want %02h/%0b",
                             out_data, out_last, e[7:0], e[8]);
                end
            end
        end
        while (probe_q.size() != 0) begin
            p = probe_q.pop_front();
            case (p.kind)
                P_VALID:   act = int'(out_valid);
                P_DATA:    act = int'(out_data);
                P_LAST:    act = int'(out_last);
                P_INFRAME: act = int'(in_frame);
                P_FCNT:    act = int'(frame_count);
                P_RDEN:    act = int'(fifo_rd_en);
                P_RDPTR:   act = rd_ptr;
                P_SBEMPTY: act = exp_q.size();
                default:   act = -1;
            endcase
            n_checks++;
            if (act != p.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h want %0h",
                         p.name, act, p.exp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic expb(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic probe(input int k, input int v, input string nm);
        probe_t p;
        p.kind = k;
        p.exp  = v;
        p.name = nm;
        probe_q.push_back(p);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || rd_ptr != wr_ptr) && n < 3000) begin
            cyc(1);
            n++;
        end
        if (n >= 3000) probe(P_TIMEOUT, 0, nm);
        cyc(2);
    endtask

    initial begin
        int base;

        cyc(1);
        probe(P_VALID,   0, "rst_valid");
        probe(P_DATA,    0, "rst_data");
        probe(P_LAST,    0, "rst_last");
        probe(P_INFRAME, 0, "rst_inframe");
        probe(P_FCNT,    0, "rst_fcnt");
        probe(P_RDEN,    0, "rst_rden");
        cyc(2);
        read_rst = 1'b0;
        cyc(2);

        // Single 3-byte frame: A1 visible three edges after the write.
        put(8'h03); put(8'hA1); put(8'hA2); put(8'hA3);
        expb(8'hA1, 0); expb(8'hA2, 0); expb(8'hA3, 1);
        cyc(3);
        probe(P_VALID,   1,     "t1_valid");
        probe(P_DATA,    'hA1,  "t1_first");
        probe(P_LAST,    0,     "t1_notlast");
        probe(P_INFRAME, 1,     "t1_inframe");
        cyc(2);
        probe(P_DATA,    'hA3,  "t1_third");
        probe(P_LAST,    1,     "t1_last");
        cyc(1);
        probe(P_VALID,   0,     "t1_idle");
        probe(P_INFRAME, 0,     "t1_inframe_fall");
        probe(P_FCNT,    1,     "t1_fcnt");
        drain("t1_drain");

        // Back-to-back: bubble while the second length is decoded.
        put(8'h01); put(8'h55);
        put(8'h02); put(8'h66); put(8'h77);
        expb(8'h55, 1); expb(8'h66, 0); expb(8'h77, 1);
        cyc(4);
        probe(P_VALID,   0, "t2_bubble");
        probe(P_INFRAME, 1, "t2_inframe_held");
        probe(P_FCNT,    2, "t2_fcnt_mid");
        cyc(1);
        probe(P_VALID,   1,     "t2_valid");
        probe(P_DATA,    'h66,  "t2_data");
        drain("t2_drain");
        probe(P_FCNT,    3, "t2_fcnt");

        // Length 0 carries 256 payload bytes; next byte is a length.
        put(8'h00);
        for (int i = 0; i < 256; i++) begin
            put(8'(i));
            expb(8'(i), (i == 255));
        end
        put(8'h01); put(8'h99);
        expb(8'h99, 1);
        drain("t3_drain");
        probe(P_FCNT,    5, "t3_fcnt");
        probe(P_INFRAME, 0, "t3_inframe");

        // Back-pressure: only length plus two payload reads.
        out_ready = 1'b0;
        base = wr_ptr;
        put(8'h0A);
        for (int i = 0; i < 10; i++) begin
            put(8'hE0 + 8'(i));
            expb(8'hE0 + 8'(i), (i == 9));
        end
        cyc(10);
        probe(P_RDPTR,   base + 3, "t4_reads");
        probe(P_RDEN,    0,        "t4_rden");
        probe(P_VALID,   1,        "t4_valid");
        probe(P_DATA,    'hE0,     "t4_hold");
        probe(P_INFRAME, 1,        "t4_inframe");
        cyc(4);
        probe(P_RDPTR,   base + 3, "t4_reads_held");
        probe(P_DATA,    'hE0,     "t4_hold2");
        out_ready = 1'b1;
        drain("t4_drain");
        probe(P_FCNT,    6, "t4_fcnt");

        // Underrun mid-frame, then resume.
        put(8'h04); put(8'hB1); put(8'hB2);
        expb(8'hB1, 0); expb(8'hB2, 0);
        expb(8'hB3, 0); expb(8'hB4, 1);
        cyc(8);
        probe(P_INFRAME, 1, "t5_inframe_paused");
        probe(P_FCNT,    6, "t5_fcnt_paused");
        put(8'hB3); put(8'hB4);
        drain("t5_drain");
        probe(P_FCNT,    7, "t5_fcnt");

        // Reset after two of five payload bytes.
        put(8'h05); put(8'hC1); put(8'hC2);
        expb(8'hC1, 0); expb(8'hC2, 0);
        drain("t6_pre");
        probe(P_INFRAME, 1, "t6_inframe_pre");
        cyc(1);
        read_rst = 1'b1;
        cyc(1);
        read_rst = 1'b0;
        probe(P_VALID,   0, "t6_valid");
        probe(P_DATA,    0, "t6_data");
        probe(P_LAST,    0, "t6_last");
        probe(P_INFRAME, 0, "t6_inframe");
        probe(P_FCNT,    0, "t6_fcnt");
        probe(P_RDEN,    0, "t6_rden");
        cyc(1);
        put(8'h02); put(8'hD1); put(8'hD2);
        expb(8'hD1, 0); expb(8'hD2, 1);
        drain("t6_drain");
        probe(P_FCNT,    1, "t6_fcnt_after");
        probe(P_INFRAME, 0, "t6_inframe_after");

        probe(P_SBEMPTY, 0, "sb_empty");
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
